// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry, LSB first.
// Latency: start sampled at edge k -> sum/carry/done valid after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, with a new start accepted in the done cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_nxt;
    logic [WIDTH-1:0] rs_nxt;

    assign s     = ra[0] ^ rb[0] ^ c;
    assign c_nxt = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));

    generate
        if (WIDTH == 1) begin : g_w1
            assign rs_nxt = s;
        end else begin : g_wn
            assign rs_nxt = {s, rs[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b and preload the carry.
                        ra    <= a;
                        rb    <= sub ? ~b : b;
                        c     <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    c   <= c_nxt;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= rs_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= rs_nxt;
                        carry <= c_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
